// File: rtl/stats_div_sequencer_if.sv
// rtl/stats_div_sequencer_if.sv - request/acknowledge handshake to a shared iterative divider
interface stats_div_sequencer_if #(
    parameter int TEMP_WIDTH = 12,
    parameter int SQ_WIDTH   = 28
);
    logic                  div_req;
    logic [SQ_WIDTH-1:0]   div_num;
    logic [TEMP_WIDTH-1:0] div_den;
    logic                  div_ack;
    logic [SQ_WIDTH-1:0]   div_quot;

    modport master (
        output div_req,
        output div_num,
        output div_den,
        input  div_ack,
        input  div_quot
    );

    modport slave (
        input  div_req,
        input  div_num,
        input  div_den,
        output div_ack,
        output div_quot
    );
endinterface

// File: rtl/stats_div_sequencer.sv
// rtl/stats_div_sequencer.sv - average and Newton-iterated stdev sequencer sharing one external divider
module stats_div_sequencer #(
    parameter int                    TEMP_WIDTH = 12,
    parameter int                    SUM_WIDTH  = 16,
    parameter int                    SQ_WIDTH   = 28,
    parameter int                    NR_ITERS   = 8,
    parameter logic [TEMP_WIDTH-1:0] INIT_STDEV = 12'h400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [3:0]            num_smpls,
    input  logic [SUM_WIDTH-1:0]  sum,
    input  logic [SQ_WIDTH-1:0]   sum_sqrd,
    stats_div_sequencer_if.master div,
    output logic                  busy,
    output logic                  done,
    output logic [TEMP_WIDTH-1:0] avg,
    output logic [TEMP_WIDTH-1:0] stdev
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_AVG,
        S_VAR,
        S_NR,
        S_FIN
    } state_t;

    localparam logic [SQ_WIDTH:0] S_MAX = (SQ_WIDTH+1)'((1 << TEMP_WIDTH) - 1);

    state_t                state_q;
    logic                  mode_q;
    logic [3:0]            n_q;
    logic [SQ_WIDTH-1:0]   sq_q;
    logic [3:0]            iter_q;
    logic [TEMP_WIDTH-1:0] s_q;
    logic [TEMP_WIDTH-1:0] avg_tmp_q;
    logic [SQ_WIDTH-1:0]   var_q;
    logic                  req_q;
    logic [SQ_WIDTH-1:0]   num_q;
    logic [TEMP_WIDTH-1:0] den_q;
    logic                  busy_q;
    logic                  done_q;
    logic [TEMP_WIDTH-1:0] avg_q;
    logic [TEMP_WIDTH-1:0] stdev_q;

    logic [TEMP_WIDTH-1:0] avg_d;
    logic [SQ_WIDTH:0]     avg_sq_d;
    logic [SQ_WIDTH:0]     var_diff_d;
    logic [SQ_WIDTH-1:0]   var_d;
    logic [SQ_WIDTH:0]     s_sum_d;
    logic [SQ_WIDTH:0]     s_half_d;
    logic [TEMP_WIDTH-1:0] s_new_d;
    logic [3:0]            iter_d;
    logic                  iter_last_d;
    logic                  ack_d;
    logic [TEMP_WIDTH-1:0] seed_d;

    // A stray ack while no request is outstanding must never advance the FSM.
    assign ack_d       = req_q && div.div_ack;
    assign avg_d       = div.div_quot[TEMP_WIDTH-1:0];
    assign avg_sq_d    = (SQ_WIDTH+1)'(avg_tmp_q) * (SQ_WIDTH+1)'(avg_tmp_q);
    assign var_diff_d  = {1'b0, div.div_quot} - avg_sq_d;
    assign var_d       = var_diff_d[SQ_WIDTH] ? '0 : var_diff_d[SQ_WIDTH-1:0];
    assign s_sum_d     = {1'b0, div.div_quot} + (SQ_WIDTH+1)'(s_q);
    assign s_half_d    = s_sum_d >> 1;
    assign s_new_d     = (s_half_d > S_MAX) ? '1 : s_half_d[TEMP_WIDTH-1:0];
    assign iter_d      = iter_q + 4'd1;
    assign iter_last_d = (iter_d == 4'(NR_ITERS));
    assign seed_d      = (stdev_q == '0) ? INIT_STDEV : stdev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            n_q       <= '0;
            sq_q      <= '0;
            iter_q    <= '0;
            s_q       <= '0;
            avg_tmp_q <= '0;
            var_q     <= '0;
            req_q     <= 1'b0;
            num_q     <= '0;
            den_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            avg_q     <= '0;
            stdev_q   <= INIT_STDEV;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        n_q    <= num_smpls;
                        sq_q   <= sum_sqrd;
                        iter_q <= '0;
                        busy_q <= 1'b1;
                        if (num_smpls == 4'd0) begin
                            avg_tmp_q <= '0;
                            var_q     <= '0;
                            s_q       <= '0;
                            state_q   <= S_FIN;
                        end else begin
                            s_q     <= seed_d;
                            req_q   <= 1'b1;
                            num_q   <= SQ_WIDTH'(sum);
                            den_q   <= TEMP_WIDTH'(num_smpls);
                            state_q <= S_AVG;
                        end
                    end
                end
                S_AVG: begin
                    if (ack_d) begin
                        avg_tmp_q <= avg_d;
                        req_q     <= 1'b0;
                        state_q   <= mode_q ? S_VAR : S_FIN;
                    end
                end
                S_VAR: begin
                    // First cycle here is the mandatory low gap after the previous ack.
                    if (!req_q) begin
                        req_q <= 1'b1;
                        num_q <= sq_q;
                        den_q <= TEMP_WIDTH'(n_q);
                    end else if (ack_d) begin
                        req_q <= 1'b0;
                        var_q <= var_d;
                        if (var_d == '0) begin
                            s_q     <= '0;
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_NR;
                        end
                    end
                end
                S_NR: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                        num_q <= var_q;
                        den_q <= s_q;
                    end else if (ack_d) begin
                        req_q  <= 1'b0;
                        s_q    <= s_new_d;
                        iter_q <= iter_d;
                        if ((s_new_d == s_q) || iter_last_d) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    done_q <= 1'b1;
                    avg_q  <= avg_tmp_q;
                    if (mode_q) begin
                        stdev_q <= s_q;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div.div_req = req_q;
    assign div.div_num = num_q;
    assign div.div_den = den_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign avg         = avg_q;
    assign stdev       = stdev_q;
endmodule
